// File: rtl/gray_binary_dec.sv
// Registered Gray-to-binary decoder with valid/ready handshake and 1-cycle latency.
// Define GRAY_STEP_CHECK_EN to build the single-bit-step checker and its error counter.
module gray_binary_dec #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             step_clr,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] bin_d, bin_q;
    logic [WIDTH-1:0] dec;
    logic             out_valid_d, out_valid_q;
    logic             accept;
    logic             run_bit;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        run_bit = 1'b0;
        dec     = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            run_bit = run_bit ^ gray_in[i];
            dec[i]  = run_bit;
        end
    end

    always_comb begin
        bin_d       = bin_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            bin_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = out_valid_q;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [WIDTH-1:0] DiffOne = WIDTH'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [WIDTH-1:0] prev_gray_d, prev_gray_q;
    logic             have_prev_d, have_prev_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic             step_err_d, step_err_q;
    logic [WIDTH-1:0] diff;
    logic             step_bad;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign diff     = gray_in ^ prev_gray_q;
    assign step_bad = have_prev_q && !step_clr &&
                      ((diff == '0) || ((diff & (diff - DiffOne)) != '0));

    always_comb begin
        prev_gray_d = prev_gray_q;
        have_prev_d = have_prev_q;
        err_cnt_d   = err_cnt_q;
        step_err_d  = step_err_q;
        if (accept) begin
            prev_gray_d = gray_in;
            have_prev_d = 1'b1;
            step_err_d  = step_bad;
        end else if (step_clr) begin
            have_prev_d = 1'b0;
        end
        if (step_clr) begin
            err_cnt_d = '0;
        end else if (accept && step_bad && (err_cnt_q != CntMax)) begin
            err_cnt_d = err_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= '0;
            step_err_q  <= 1'b0;
        end else begin
            prev_gray_q <= prev_gray_d;
            have_prev_q <= have_prev_d;
            err_cnt_q   <= err_cnt_d;
            step_err_q  <= step_err_d;
        end
    end

    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_step_clr;

    assign unused_step_clr = step_clr;
    assign step_err        = 1'b0;
    assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_gray_binary_dec.sv
// Self-checking bench for gray_binary_dec: directed scenarios plus a randomized run
// scored against a transaction-level model of decode, handshake and step checking.
module tb_gray_binary_dec;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 2;
    localparam int unsigned CntMax = (1 << CW) - 1;
`ifdef GRAY_STEP_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  gray_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  bin_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          step_clr = 1'b0;
    logic          step_err;
    logic [CW-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_valid;
    logic [W-1:0] m_bin;
    bit          m_err;
    int          m_cnt;
    logic [W-1:0] m_prev;
    bit          m_have;
    bit          obs_ready;
    bit          exp_ready;

    gray_binary_dec #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_clr  (step_clr),
        .step_err  (step_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b = '0;
        for (int s = 0; s < int'(W); s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bin = '0; m_err = 0; m_cnt = 0; m_prev = '0; m_have = 0;
    endtask

    // Drives one cycle (called at posedge+1), updates the model, returns at next posedge+1.
    task automatic tick(input bit v, input logic [W-1:0] g, input bit rdy, input bit clr);
        bit acc;
        bit err;
        in_valid = v; gray_in = g; out_ready = rdy; step_clr = clr;
        #1;
        obs_ready = in_ready;
        exp_ready = !m_valid || rdy;
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        err = ChkEn && acc && !clr && m_have && ($countones(g ^ m_prev) != 1);
        if (acc) begin
            m_bin = gray2bin(g); m_err = err; m_valid = 1;
            m_prev = g; m_have = 1;
        end else begin
            if (rdy) m_valid = 0;
            if (clr) m_have = 0;
        end
        if (ChkEn && clr) m_cnt = 0;
        else if (err && m_cnt < int'(CntMax)) m_cnt++;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (bin_out !== '0 || out_valid !== 1'b0 || err_cnt !== '0 || step_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_init: bin=%h v=%b cnt=%0d err=%b, want 0", bin_out, out_valid,
                     err_cnt, step_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(1, 8'h0F, 0, 0);
        n_checks++;
        if (bin_out !== 8'h0A || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_preload: bin=%h v=%b, want 0a 1", bin_out, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bin_out !== '0 || out_valid !== 1'b0 || err_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_async: bin=%h v=%b cnt=%0d, want 0 0 0", bin_out, out_valid,
                     err_cnt);
        end
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] codes [16] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                                     8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};
        for (int i = 0; i < 16; i++) begin
            tick(1, codes[i], 1, 0);
            n_checks++;
            if (obs_ready !== 1'b1 || out_valid !== 1'b1 || bin_out !== W'(i) ||
                bin_out !== m_bin || step_err !== 1'b0 || err_cnt !== '0) begin
                n_errors++;
                $display("FAIL stream[%0d]: rdy=%b v=%b bin=%h err=%b cnt=%0d, want 1 1 %h 0 0",
                         i, obs_ready, out_valid, bin_out, step_err, err_cnt, W'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        tick(1, 8'h07, 1, 0);
        n_checks++;
        if (bin_out !== 8'h05 || out_valid !== 1'b1 || err_cnt !== CW'(m_cnt)) begin
            n_errors++;
            $display("FAIL bp_load: bin=%h v=%b cnt=%0d, want 05 1 %0d", bin_out, out_valid,
                     err_cnt, m_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'h05, 0, 0);
            n_checks++;
            if (obs_ready !== 1'b0 || bin_out !== 8'h05 || out_valid !== 1'b1 ||
                step_err !== m_err) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: rdy=%b bin=%h v=%b err=%b, want 0 05 1 %b", i,
                         obs_ready, bin_out, out_valid, step_err, m_err);
            end
        end
        tick(1, 8'h05, 1, 0);
        n_checks++;
        if (obs_ready !== 1'b1 || bin_out !== 8'h06 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: rdy=%b bin=%h v=%b, want 1 06 1", obs_ready, bin_out,
                     out_valid);
        end
    endtask

    task automatic test_step_error();
        tick(0, 8'h00, 1, 1);
        tick(1, 8'h02, 1, 0);
        n_checks++;
        if (bin_out !== 8'h03 || step_err !== 1'b0 || err_cnt !== '0) begin
            n_errors++;
            $display("FAIL step_first: bin=%h err=%b cnt=%0d, want 03 0 0", bin_out, step_err,
                     err_cnt);
        end
        for (int i = 1; i <= 2; i++) begin
            tick(1, 8'h07, 1, 0);
            n_checks++;
            if (bin_out !== 8'h05 || step_err !== ChkEn || err_cnt !== CW'(ChkEn ? i : 0) ||
                err_cnt !== CW'(m_cnt)) begin
                n_errors++;
                $display("FAIL step_err[%0d]: bin=%h err=%b cnt=%0d, want 05 %b %0d", i,
                         bin_out, step_err, err_cnt, ChkEn, ChkEn ? i : 0);
            end
        end
    endtask

    task automatic test_wrap_sat();
        tick(1, 8'h80, 1, 1);
        n_checks++;
        if (bin_out !== 8'hFF || step_err !== 1'b0 || err_cnt !== '0) begin
            n_errors++;
            $display("FAIL wrap_80: bin=%h err=%b cnt=%0d, want ff 0 0", bin_out, step_err,
                     err_cnt);
        end
        tick(1, 8'h00, 1, 0);
        n_checks++;
        if (bin_out !== 8'h00 || step_err !== 1'b0 || err_cnt !== '0) begin
            n_errors++;
            $display("FAIL wrap_00: bin=%h err=%b cnt=%0d, want 00 0 0", bin_out, step_err,
                     err_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1, 8'h00, 1, 0);
            n_checks++;
            if (step_err !== ChkEn || err_cnt !== CW'(ChkEn ? (i > 3 ? 3 : i) : 0) ||
                err_cnt !== CW'(m_cnt)) begin
                n_errors++;
                $display("FAIL sat[%0d]: err=%b cnt=%0d, want %b %0d", i, step_err, err_cnt,
                         ChkEn, ChkEn ? (i > 3 ? 3 : i) : 0);
            end
        end
    endtask

    task automatic test_clear();
        logic [W-1:0] seq [4] = '{8'h33, 8'h32, 8'h30, 8'h3F};
        bit           bad [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick(1, seq[i], 1, i == 0);
            n_checks++;
            if (bin_out !== gray2bin(seq[i]) || step_err !== (bad[i] && ChkEn) ||
                err_cnt !== CW'(bad[i] && ChkEn)) begin
                n_errors++;
                $display("FAIL clear[%0d]: bin=%h err=%b cnt=%0d, want %h %b %0d", i, bin_out,
                         step_err, err_cnt, gray2bin(seq[i]), bad[i] && ChkEn,
                         bad[i] && ChkEn);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] g;
        logic [W-1:0] last_g = m_prev;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) g = last_g ^ W'(1 << $urandom_range(0, W - 1));
            else if ($urandom_range(0, 1) != 0) g = last_g;
            else g = W'($urandom);
            tick($urandom_range(0, 3) != 0, g, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
            if (in_valid && obs_ready) last_g = g;
            n_checks++;
            if (obs_ready !== exp_ready || out_valid !== m_valid || bin_out !== m_bin ||
                step_err !== m_err || err_cnt !== CW'(m_cnt)) begin
                n_errors++;
                $display("FAIL random[%0d]: rdy=%b v=%b bin=%h err=%b cnt=%0d, want %b %b %h %b %0d",
                         i, obs_ready, out_valid, bin_out, step_err, err_cnt, exp_ready, m_valid,
                         m_bin, m_err, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_step_error();
        test_wrap_sat();
        test_clear();
        test_random();
        in_valid = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
